// File: rtl/bus_fabric.sv
// CPU-to-peripheral interconnect: base/mask address decode, per-slave wait states,
// write-strobe gating, registered read-data select and a sticky unmapped-access record.
module bus_fabric #(
  parameter int                  NSLV     = 5,
  parameter logic [NSLV*16-1:0]  SLV_BASE = '0,
  parameter logic [NSLV*16-1:0]  SLV_MASK = '0,
  parameter logic [NSLV*4-1:0]   SLV_WS   = '0,
  parameter logic [7:0]          OPEN_BUS = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [7:0]        dbw,
  input  logic              we,
  output logic [7:0]        dbr,
  output logic              rdy,
  output logic [NSLV-1:0]   sel,
  output logic [NSLV-1:0]   swe,
  input  logic [NSLV*8-1:0] sdbr,
  output logic              err,
  output logic [15:0]       err_addr,
  output logic              err_we,
  input  logic              err_clr,
  output logic              state_dbg
);

  // Handshake: an access completes on every cycle where rdy=1; while rdy=0 the
  // CPU must hold addr/we/dbw stable. swe and the error record act only on completion.

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [NSLV-1:0] cs_q;
  logic [3:0]      ws_sel;

  // Walk from the highest index down so the lowest-index hit wins on overlap.
  always_comb begin
    sel    = '0;
    ws_sel = 4'd0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (((addr ^ SLV_BASE[16*k +: 16]) & SLV_MASK[16*k +: 16]) == 16'h0000) begin
        sel    = '0;
        sel[k] = 1'b1;
        ws_sel = SLV_WS[4*k +: 4];
      end
    end
  end

  always_comb begin
    rdy = 1'b0;
    case (state)
      IDLE:    rdy = (ws_sel == 4'd0);
      WAIT:    rdy = (cnt == 4'd0);
      default: rdy = 1'b0;
    endcase
  end

  assign swe       = sel & {NSLV{we & rdy}};
  assign state_dbg = state;

  // Registered select drives the read mux one cycle after completion.
  always_comb begin
    dbr = 8'hFF;
    for (int k = 0; k < NSLV; k++) begin
      if (cs_q[k]) dbr = dbr & sdbr[8*k +: 8];
    end
    if (cs_q == '0) dbr = OPEN_BUS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cs_q     <= '0;
      err      <= 1'b0;
      err_addr <= 16'h0000;
      err_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ws_sel != 4'd0) begin
            state <= WAIT;
            cnt   <= ws_sel - 4'd1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (rdy) cs_q <= sel;

      // A new unmapped access takes priority over a coincident clear.
      if (rdy && (sel == '0)) begin
        err      <= 1'b1;
        err_addr <= addr;
        err_we   <= we;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
